// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared FSM encoding, default timing and MAX7219 register addresses
package spi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD       = 3'd1,
        ST_SHIFT      = 3'd2,
        ST_HOLD       = 3'd3,
        ST_GAP        = 3'd4,
        ST_CHAIN_WAIT = 3'd5
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_CS_GAP  = 2;

    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - reloadable down-counter emitting one phase tick every CLK_DIV enabled cycles
module spi_clk_div
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW     = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    // Every tick is a phase change, so reloading on tick keeps phases aligned.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (!en_i || tick_o) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/max7219_spi_tx.sv
// rtl/max7219_spi_tx.sv - MAX7219 SPI mode-0 word serializer; SPI_TX_CHAIN_EN adds in_last cascading
module max7219_spi_tx
    import spi_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef SPI_TX_CHAIN_EN
    input  logic              in_last,
`endif
    output logic              done,
    output logic              spi_clk,
    output logic              spi_cs_n,
    output logic              spi_mosi
);

    localparam int BW = cnt_w(DATA_W);
    localparam int GW = cnt_w(CS_GAP);

    state_e            state_q, state_d;
    logic              high_q, high_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              done_q, done_d;
`ifdef SPI_TX_CHAIN_EN
    logic              last_q, last_d;
`endif
    logic              tick;
    logic              div_en;
    logic              accept;

    assign div_en = (state_q == ST_LEAD) || (state_q == ST_SHIFT) ||
                    (state_q == ST_HOLD) || (state_q == ST_GAP);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (div_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
`ifdef SPI_TX_CHAIN_EN
        last_d   = last_q;
        in_ready = (state_q == ST_IDLE) || (state_q == ST_CHAIN_WAIT);
`else
        in_ready = (state_q == ST_IDLE);
`endif
        accept   = in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    bit_d   = BW'(DATA_W - 1);
`ifdef SPI_TX_CHAIN_EN
                    last_d  = in_last;
`endif
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    high_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The next bit is presented on the falling transition only.
                if (tick) begin
                    high_d = !high_q;
                    if (high_q) begin
                        if (bit_q == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            shreg_d = shreg_q << 1;
                            bit_d   = bit_q - 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
`ifdef SPI_TX_CHAIN_EN
                    if (!last_q) begin
                        state_d = ST_CHAIN_WAIT;
                    end else begin
                        gap_d   = GW'(CS_GAP - 1);
                        done_d  = 1'b1;
                        state_d = ST_GAP;
                    end
`else
                    gap_d   = GW'(CS_GAP - 1);
                    done_d  = 1'b1;
                    state_d = ST_GAP;
`endif
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
`ifdef SPI_TX_CHAIN_EN
            ST_CHAIN_WAIT: begin
                // cs_n stays low; the next word starts straight on its first rising half.
                if (accept) begin
                    shreg_d = in_data;
                    bit_d   = BW'(DATA_W - 1);
                    last_d  = in_last;
                    high_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            high_q  <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
`ifdef SPI_TX_CHAIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
`ifdef SPI_TX_CHAIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign spi_clk  = (state_q == ST_SHIFT) && high_q;
    assign spi_cs_n = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign spi_mosi = shreg_q[DATA_W-1];
    assign done     = done_q;

endmodule

// File: tb/tb_max7219_spi_tx.sv
// tb/tb_max7219_spi_tx.sv - table-driven bench for max7219_spi_tx (CLK_DIV=4 and CLK_DIV=1 instances)
module tb_max7219_spi_tx;
    import spi_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, done, spi_clk, spi_cs_n, spi_mosi;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b1;
    logic        v1 = 1'b0, rdy1, done1, sclk1, cs1, mosi1;
    logic [15:0] d1 = '0;
    logic        last1 = 1'b1;

    always #5 clk = ~clk;

    max7219_spi_tx #(.DATA_W(16), .CLK_DIV(4), .CS_GAP(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SPI_TX_CHAIN_EN
        .in_last(in_last),
`endif
        .done(done), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi));

    max7219_spi_tx #(.DATA_W(16), .CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
`ifdef SPI_TX_CHAIN_EN
        .in_last(last1),
`endif
        .done(done1), .spi_clk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1));

    typedef struct {
        logic [63:0] word;
        int          rises;
        int          cs_low;
    } frame_t;

    typedef struct {
        logic [15:0] word;
        int          rises;
        int          cs_low;
        int          ready_low;
    } vec_t;

    frame_t      fq[$];
    frame_t      fq1[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [63:0] cap;
    int          rises, cs_low, hi_cnt, last_gap, done_cnt, done_bad;
    logic        prev_cs, prev_sclk;
    logic [15:0] cap1;
    int          rises1, cs_low1, viol1;
    logic        prev_cs1, prev_sclk1, prev_mosi1;

    // Monitors sample on the falling clk edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            cap <= '0; rises <= 0; cs_low <= 0; prev_cs <= 1'b1; prev_sclk <= 1'b0;
            cap1 <= '0; rises1 <= 0; cs_low1 <= 0; prev_cs1 <= 1'b1; prev_sclk1 <= 1'b0;
            prev_mosi1 <= 1'b0; hi_cnt <= 0;
        end else begin
            prev_cs   <= spi_cs_n;
            prev_sclk <= spi_clk;
            if (done) done_cnt <= done_cnt + 1;
            if (done && !(spi_cs_n && !prev_cs)) done_bad <= done_bad + 1;
            if (spi_cs_n) hi_cnt <= prev_cs ? hi_cnt + 1 : 1;
            if (!spi_cs_n && prev_cs) last_gap <= hi_cnt;
            if (spi_cs_n && !prev_cs) begin
                fq.push_back('{cap, rises, cs_low});
                cap <= '0; rises <= 0; cs_low <= 0;
            end else begin
                if (!spi_cs_n) cs_low <= cs_low + 1;
                if (spi_clk && !prev_sclk) begin
                    rises <= rises + 1;
                    cap   <= {cap[62:0], spi_mosi};
                end
            end

            prev_cs1   <= cs1;
            prev_sclk1 <= sclk1;
            prev_mosi1 <= mosi1;
            if (!cs1 && !prev_cs1 && (mosi1 != prev_mosi1) && !(prev_sclk1 && !sclk1))
                viol1 <= viol1 + 1;
            if (cs1 && !prev_cs1) begin
                fq1.push_back('{{48'h0, cap1}, rises1, cs_low1});
                cap1 <= '0; rises1 <= 0; cs_low1 <= 0;
            end else begin
                if (!cs1) cs_low1 <= cs_low1 + 1;
                if (sclk1 && !prev_sclk1) begin
                    rises1 <= rises1 + 1;
                    cap1   <= {cap1[14:0], mosi1};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send4(input logic [15:0] w, output int rl);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        rl = 0;
        while (!in_ready && rl < 2000) begin @(negedge clk); rl++; end
    endtask

    task automatic send1(input logic [15:0] w);
        int n = 0;
        v1 = 1'b1;
        d1 = w;
        while (!rdy1 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        d1 = 16'($urandom);
        n = 0;
        while (!rdy1 && n < 2000) begin @(negedge clk); n++; end
    endtask

    task automatic pop_frame(input string name, output frame_t f);
        if (fq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no frame observed, expected one", name);
            f = '{64'hDEAD, -1, -1};
        end else begin
            f = fq.pop_front();
        end
    endtask

    vec_t   vt[5];
    frame_t f;
    int     rl, d0, nf, n;

    initial begin
        done_cnt = 0; done_bad = 0; viol1 = 0; last_gap = 0;
        vt[0] = '{16'h0C01, 16, 132, 140};
        vt[1] = '{{REG_INTENSITY, 8'h0F}, 16, 132, 140};
        vt[2] = '{16'hA5F0, 16, 132, 140};
        vt[3] = '{16'h8000, 16, 132, 140};
        vt[4] = '{16'h0001, 16, 132, 140};

        repeat (3) @(negedge clk);
        chk("reset cs_n",     {63'h0, spi_cs_n}, 64'h1);
        chk("reset spi_clk",  {63'h0, spi_clk},  64'h0);
        chk("reset mosi",     {63'h0, spi_mosi}, 64'h0);
        chk("reset done",     {63'h0, done},     64'h0);
        chk("reset in_ready", {63'h0, in_ready}, 64'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            send4(vt[i].word, rl);
            pop_frame("vec frame", f);
            chk($sformatf("vec%0d word", i),      f.word, {48'h0, vt[i].word});
            chk($sformatf("vec%0d rises", i),     64'(f.rises), 64'(vt[i].rises));
            chk($sformatf("vec%0d cs_low", i),    64'(f.cs_low), 64'(vt[i].cs_low));
            chk($sformatf("vec%0d ready_low", i), 64'(rl), 64'(vt[i].ready_low));
            chk($sformatf("vec%0d done", i),      64'(done_cnt - d0), 64'd1);
        end

        // Back-to-back: in_valid never drops; gap is 8 GAP cycles plus the accepting IDLE cycle.
        in_valid = 1'b1;
        in_data  = 16'h0A0F;
        n = 0;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        in_data = 16'h0B07;
        n = 0;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        pop_frame("b2b first", f);
        chk("b2b word0", f.word, 64'h0A0F);
        pop_frame("b2b second", f);
        chk("b2b word1", f.word, 64'h0B07);
        chk("b2b cs high gap", 64'(last_gap), 64'd9);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        nf = fq.size();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rises < 6 && n < 2000) begin @(negedge clk); n++; end
        chk("midreset reached bit5", 64'(rises >= 6), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset cs_n", {63'h0, spi_cs_n}, 64'h1);
        chk("midreset done", {63'h0, done}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset no frame", 64'(fq.size()), 64'(nf));
        chk("midreset no done",  64'(done_cnt - d0), 64'd0);
        send4(16'h0C01, rl);
        pop_frame("post-reset frame", f);
        chk("post-reset word", f.word, 64'h0C01);
        chk("post-reset cs_low", 64'(f.cs_low), 64'd132);

        // CLK_DIV=1 instance: spi_clk = clk/2.
        send1(16'hFFFF);
        send1(16'h0000);
        if (fq1.size() != 2) begin
            n_cmp++; n_fail++;
            $display("FAIL div1 frames: got %0d, expected 2", fq1.size());
        end else begin
            f = fq1.pop_front();
            chk("div1 word0",   f.word, 64'hFFFF);
            chk("div1 cs_low0", 64'(f.cs_low), 64'd33);
            f = fq1.pop_front();
            chk("div1 word1",   f.word, 64'h0000);
            chk("div1 rises1",  64'(f.rises), 64'd16);
        end
        chk("div1 mosi stable", 64'(viol1), 64'd0);

`ifdef SPI_TX_CHAIN_EN
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0101 * 16'(i + 1);
            in_last  = (i == 3);
            n = 0;
            while (!in_ready && n < 2000) begin @(negedge clk); n++; end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!in_ready && n < 2000) begin @(negedge clk); n++; end
            if (i < 3) chk("chain wait cs_n low", {63'h0, spi_cs_n}, 64'h0);
        end
        in_last = 1'b1;
        pop_frame("chain frame", f);
        chk("chain word",  f.word, 64'h0101_0202_0303_0404);
        chk("chain rises", 64'(f.rises), 64'd64);
        chk("chain done",  64'(done_cnt - d0), 64'd1);
`endif

        chk("done aligned with cs rise", 64'(done_bad), 64'd0);
        chk("no stray frames", 64'(fq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
